// File: rtl/axi_lite_cmd_master_if.sv
// Command/response and AXI-Lite bus bundle for axi_lite_cmd_master.
interface axi_lite_cmd_master_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_rw;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_rw;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic [1:0]            rsp_resp;

   logic                  awvalid;
   logic                  awready;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic                  wvalid;
   logic                  wready;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  bvalid;
   logic                  bready;
   logic [1:0]            bresp;
   logic                  arvalid;
   logic                  arready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic                  rvalid;
   logic                  rready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;

   modport master (
      input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
      output cmd_ready,
      output rsp_valid, rsp_rw, rsp_rdata, rsp_resp,
      input  rsp_ready,
      output awvalid, awaddr, wvalid, wdata, bready,
      input  awready, wready, bvalid, bresp,
      output arvalid, araddr, rready,
      input  arready, rvalid, rdata, rresp
   );

   modport slave (
      output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
      input  cmd_ready,
      input  rsp_valid, rsp_rw, rsp_rdata, rsp_resp,
      output rsp_ready,
      input  awvalid, awaddr, wvalid, wdata, bready,
      output awready, wready, bvalid, bresp,
      input  arvalid, araddr, rready,
      output arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding command to AXI-Lite master; every output is a flop
// loaded from the next-state logic so no input reaches an output combinationally.
module axi_lite_cmd_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  aclk,
   input  logic                  areset,
   axi_lite_cmd_master_if.master bus,
   output logic [15:0]           err_count
);
   typedef enum logic [2:0] {
      IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP_OUT
   } state_t;

   state_t state, state_nx;

   logic                  cmd_ready, cmd_ready_nx;
   logic                  awvalid, awvalid_nx;
   logic                  wvalid, wvalid_nx;
   logic                  bready, bready_nx;
   logic                  arvalid, arvalid_nx;
   logic                  rready, rready_nx;
   logic                  rsp_valid, rsp_valid_nx;
   logic                  rsp_rw, rsp_rw_nx;
   logic [1:0]            rsp_resp, rsp_resp_nx;
   logic [DATA_WIDTH-1:0] rsp_rdata, rsp_rdata_nx;
   logic [DATA_WIDTH-1:0] wdata, wdata_nx;
   logic [ADDR_WIDTH-1:0] awaddr, awaddr_nx;
   logic [ADDR_WIDTH-1:0] araddr, araddr_nx;
   logic [15:0]           err_nx;
   logic                  accept;
   logic                  aw_ok, w_ok;
   logic                  resp_err;

   assign accept = bus.cmd_valid & cmd_ready;
   // A channel counts as done once its VALID has already dropped
   assign aw_ok  = ~awvalid | bus.awready;
   assign w_ok   = ~wvalid | bus.wready;

   always_comb begin
      state_nx     = state;
      cmd_ready_nx = cmd_ready;
      awvalid_nx   = awvalid;
      wvalid_nx    = wvalid;
      bready_nx    = bready;
      arvalid_nx   = arvalid;
      rready_nx    = rready;
      rsp_valid_nx = rsp_valid;
      rsp_rw_nx    = rsp_rw;
      rsp_resp_nx  = rsp_resp;
      rsp_rdata_nx = rsp_rdata;
      wdata_nx     = wdata;
      awaddr_nx    = awaddr;
      araddr_nx    = araddr;
      resp_err     = 1'b0;
      unique case (state)
         IDLE: begin
            cmd_ready_nx = ~accept;
            if (accept) begin
               rsp_rw_nx = bus.cmd_rw;
               if (bus.cmd_rw) begin
                  state_nx   = RD_REQ;
                  araddr_nx  = bus.cmd_addr;
                  arvalid_nx = 1'b1;
               end else begin
                  state_nx   = WR_REQ;
                  awaddr_nx  = bus.cmd_addr;
                  wdata_nx   = bus.cmd_wdata;
                  awvalid_nx = 1'b1;
                  wvalid_nx  = 1'b1;
               end
            end
         end
         WR_REQ: begin
            if (awvalid & bus.awready) awvalid_nx = 1'b0;
            if (wvalid & bus.wready)   wvalid_nx  = 1'b0;
            if (aw_ok & w_ok) begin
               state_nx  = WR_RESP;
               bready_nx = 1'b1;
            end
         end
         WR_RESP: begin
            if (bus.bvalid & bready) begin
               state_nx     = RSP_OUT;
               bready_nx    = 1'b0;
               rsp_valid_nx = 1'b1;
               rsp_resp_nx  = bus.bresp;
               rsp_rdata_nx = '0;
               resp_err     = (bus.bresp != 2'b00);
            end
         end
         RD_REQ: begin
            if (arvalid & bus.arready) begin
               state_nx   = RD_DATA;
               arvalid_nx = 1'b0;
               rready_nx  = 1'b1;
            end
         end
         RD_DATA: begin
            if (bus.rvalid & rready) begin
               state_nx     = RSP_OUT;
               rready_nx    = 1'b0;
               rsp_valid_nx = 1'b1;
               rsp_resp_nx  = bus.rresp;
               rsp_rdata_nx = bus.rdata;
               resp_err     = (bus.rresp != 2'b00);
            end
         end
         RSP_OUT: begin
            if (bus.rsp_ready) begin
               state_nx     = IDLE;
               rsp_valid_nx = 1'b0;
               cmd_ready_nx = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      err_nx = err_count;
      if (resp_err && err_count != 16'hFFFF)
         err_nx = err_count + 16'd1;
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state     <= IDLE;
         cmd_ready <= 1'b0;
         awvalid   <= 1'b0;
         wvalid    <= 1'b0;
         bready    <= 1'b0;
         arvalid   <= 1'b0;
         rready    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rw    <= 1'b0;
         rsp_resp  <= 2'b00;
         rsp_rdata <= '0;
         wdata     <= '0;
         awaddr    <= '0;
         araddr    <= '0;
         err_count <= 16'd0;
      end else begin
         state     <= state_nx;
         cmd_ready <= cmd_ready_nx;
         awvalid   <= awvalid_nx;
         wvalid    <= wvalid_nx;
         bready    <= bready_nx;
         arvalid   <= arvalid_nx;
         rready    <= rready_nx;
         rsp_valid <= rsp_valid_nx;
         rsp_rw    <= rsp_rw_nx;
         rsp_resp  <= rsp_resp_nx;
         rsp_rdata <= rsp_rdata_nx;
         wdata     <= wdata_nx;
         awaddr    <= awaddr_nx;
         araddr    <= araddr_nx;
         err_count <= err_nx;
      end
   end

   assign bus.cmd_ready = cmd_ready;
   assign bus.awvalid   = awvalid;
   assign bus.awaddr    = awaddr;
   assign bus.wvalid    = wvalid;
   assign bus.wdata     = wdata;
   assign bus.bready    = bready;
   assign bus.arvalid   = arvalid;
   assign bus.araddr    = araddr;
   assign bus.rready    = rready;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_rw    = rsp_rw;
   assign bus.rsp_resp  = rsp_resp;
   assign bus.rsp_rdata = rsp_rdata;
endmodule

// File: doc/axi_lite_cmd_master.md
AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of CMD_ADDR/AWADDR/ARADDR.
REQ-002 Parameter DATA_WIDTH, default 32, width of CMD_WDATA/WDATA/RDATA/RSP_RDATA.
REQ-003 ACLK  in  1  single clock; all logic on rising edge.
REQ-004 ARESET  in  1  asynchronous, active-high reset.
REQ-005 CMD_VALID  in  1  command request; CMD_READY  out  1  command accept.
REQ-006 CMD_RW  in  1  0=write, 1=read; CMD_ADDR  in  ADDR_WIDTH; CMD_WDATA  in  DATA_WIDTH.
REQ-007 RSP_VALID  out  1; RSP_READY  in  1; RSP_RW  out  1; RSP_RDATA  out  DATA_WIDTH; RSP_RESP  out  2.
REQ-008 AWVALID out 1, AWREADY in 1, AWADDR out ADDR_WIDTH: AXI-Lite write address channel.
REQ-009 WVALID out 1, WREADY in 1, WDATA out DATA_WIDTH: write data channel.
REQ-010 BVALID in 1, BREADY out 1, BRESP in 2: write response channel.
REQ-011 ARVALID out 1, ARREADY in 1, ARADDR out ADDR_WIDTH: read address channel.
REQ-012 RVALID in 1, RREADY out 1, RDATA in DATA_WIDTH, RRESP in 2: read data channel.
REQ-013 ERR_COUNT  out  16  count of transactions completed with non-OKAY response.

Function
REQ-014 FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP_OUT; one transaction outstanding at a time.
REQ-015 CMD_READY = 1 only in IDLE; command accepted on cycle with CMD_VALID & CMD_READY.
REQ-016 On accept: latch CMD_ADDR/CMD_WDATA/CMD_RW; go to WR_REQ (RW=0) or RD_REQ (RW=1).
REQ-017 WR_REQ: AWVALID and WVALID both assert the cycle after accept, with AWADDR/WDATA from latched values.
REQ-018 Each of AWVALID/WVALID deasserts independently the cycle after its own handshake; each stays high until handshake (no withdrawal).
REQ-019 WR_REQ -> WR_RESP once both AW and W handshakes have occurred (same or different cycles, either order).
REQ-020 WR_RESP: BREADY = 1; on BVALID & BREADY capture BRESP into RSP_RESP, go to RSP_OUT.
REQ-021 RD_REQ: ARVALID asserts cycle after accept, holds until ARREADY; then -> RD_DATA.
REQ-022 RD_DATA: RREADY = 1; on RVALID & RREADY capture RDATA, RRESP; go to RSP_OUT.
REQ-023 RSP_OUT: RSP_VALID = 1 with RSP_RW, RSP_RDATA, RSP_RESP stable until RSP_READY; then -> IDLE.
REQ-024 RSP_RDATA on write response = 0.
REQ-025 BREADY/RREADY only asserted in WR_RESP/RD_DATA respectively; BVALID/RVALID in other states ignored.
REQ-026 Minimum command-to-RSP_VALID latency with all READY/VALID inputs pre-asserted: 3 cycles (accept edge N, AW/W or AR handshake N+1, B/R handshake N+2, RSP_VALID N+3).
REQ-027 RSP_OUT -> IDLE with RSP_READY: CMD_READY high the following cycle (no back-to-back accept in RSP_OUT).
REQ-028 ERR_COUNT increments by 1 on B or R handshake with resp != 2'b00; saturates at 16'hFFFF.
REQ-029 All AXI and RSP outputs registered (no combinational path from any input to any output).

Reset
REQ-030 ARESET asserted: state -> IDLE immediately; AWVALID, WVALID, ARVALID, BREADY, RREADY, RSP_VALID, CMD_READY-driving state, RSP_RW, RSP_RESP, RSP_RDATA, AWADDR, WDATA, ARADDR, ERR_COUNT all 0.
REQ-031 Reset mid-transaction abandons it; no response issued; first command after deassertion accepted normally.
REQ-032 CMD_READY = 1 on first clock edge after ARESET deasserts.

Verification
REQ-033 Write, slave ready: CMD write addr 0x10, data 0xA5C3 -> AWADDR=0x10, WDATA=0xA5C3 handshake same cycle; BRESP=00 -> RSP_VALID, RSP_RW=0, RSP_RESP=00, RSP_RDATA=0, 3 cycles after accept.
REQ-034 Skewed write: AWREADY at +1, WREADY at +4 -> AWVALID drops after +1, WVALID held to +4, BREADY only after +4; single response.
REQ-035 Read: addr 0x24, slave ARREADY delayed 2 cycles, RDATA=0xDEADBEEF RRESP=00 -> RSP_RDATA=0xDEADBEEF, RSP_RW=1, ERR_COUNT unchanged.
REQ-036 Errors: write BRESP=10 then read RRESP=11 -> RSP_RESP 10 then 11, ERR_COUNT=2; preload-free saturation check at 0xFFFF stays 0xFFFF.
REQ-037 Backpressure: RSP_READY low 5 cycles -> RSP fields stable, CMD_READY low, new CMD_VALID not accepted until after RSP_READY.
REQ-038 ARESET pulsed while in WR_REQ with AWREADY=0 -> all VALID/READY outputs 0 same cycle, no RSP_VALID, next write completes correctly.
